// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// master FSM state encoding used by axil_master_port.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access for every request.
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/axil_master_port_if.sv
// AXI4-Lite bus bundle. The master modport drives requests and ready for the
// response channels; the slave modport is the mirror image.
interface axil_master_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/axil_master_port.sv
// Single-outstanding AXI4-Lite master. A user command (read or write) is
// registered on acceptance and turned into AW/W/B or AR/R traffic; the result
// comes back as a one-cycle rsp_valid pulse with data and response code.
// Every AXI output is a flop, so there is no combinational path from the bus
// inputs back to the bus outputs.
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to add a sticky watchdog
// flag o_timeout that sets after TIMEOUT_CYC cycles spent outside IDLE.
module axil_master_port
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic                         i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]        i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]        i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]      i_cmd_wstrb,
  output logic                         o_rsp_valid,
  output logic [DATA_WIDTH-1:0]        o_rsp_rdata,
  output logic [1:0]                   o_rsp_resp,
  axil_master_port_if.master           m_axil
`ifdef AXIL_MASTER_TIMEOUT_EN
  ,
  output logic                         o_timeout
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  // A channel counts as done once its valid is already low or is being
  // accepted this cycle; AW and W are tracked independently.
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;

  assign w_aw_hs   = r_awvalid && m_axil.awready;
  assign w_w_hs    = r_wvalid  && m_axil.wready;
  assign w_aw_done = !r_awvalid || m_axil.awready;
  assign w_w_done  = !r_wvalid  || m_axil.wready;

  // Command FSM with all bus and user outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      r_rsp_valid <= 1'b0;
      // Ready returns the cycle after the completion pulse, so a command held
      // across a completion is taken one cycle after rsp_valid.
      if (r_rsp_valid) r_cmd_ready <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= i_cmd_addr;
            if (i_cmd_write) begin
              r_wdata   <= i_cmd_wdata;
              r_wstrb   <= i_cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end
        end

        ST_WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (m_axil.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= m_axil.bresp;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        ST_RD_REQ: begin
          if (m_axil.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (m_axil.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= m_axil.rdata;
            r_rsp_resp  <= m_axil.rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

  logic [TW-1:0] r_tcnt;
  logic          r_timeout;

  // Watchdog: count busy cycles, saturate at the limit, flag stays set until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TLIM) begin
      r_tcnt <= r_tcnt + TW'(1);
      if (r_tcnt == TLIM - TW'(1)) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`endif

  assign o_cmd_ready    = r_cmd_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_resp     = r_rsp_resp;

  assign m_axil.awaddr  = r_addr;
  assign m_axil.awprot  = PROT_DEFAULT;
  assign m_axil.awvalid = r_awvalid;
  assign m_axil.wdata   = r_wdata;
  assign m_axil.wstrb   = r_wstrb;
  assign m_axil.wvalid  = r_wvalid;
  assign m_axil.bready  = r_bready;
  assign m_axil.araddr  = r_addr;
  assign m_axil.arprot  = PROT_DEFAULT;
  assign m_axil.arvalid = r_arvalid;
  assign m_axil.rready  = r_rready;

endmodule

// File: tb/tb_axil_master_port.sv
// Directed bench for axil_master_port against a small axil_ram-style slave
// with knobs for W-ready delay, error responses and a missing B response.
module tb_axil_master_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_write = 1'b0;
  logic [4:0]  i_cmd_addr  = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [3:0]  i_cmd_wstrb = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic        o_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  axil_master_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  axil_master_port #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_write (i_cmd_write),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_wdata (i_cmd_wdata),
    .i_cmd_wstrb (i_cmd_wstrb),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_resp  (o_rsp_resp),
    .m_axil      (bus)
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int          cfg_wdly  = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  logic        cfg_no_b  = 1'b0;

  logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;
  logic [4:0]  s_awaddr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  int          s_wcnt;
  logic [31:0] mem [8];
  logic        s_aw_hs, s_w_hs;
  logic [4:0]  s_waddr;
  logic [31:0] s_wd;
  logic [3:0]  s_ws;

  assign bus.awready = !s_aw_got && !s_bvalid;
  assign bus.wready  = !s_w_got && !s_bvalid && (s_wcnt >= cfg_wdly);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.arready = !s_rvalid;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;
  assign s_aw_hs     = bus.awvalid && bus.awready;
  assign s_w_hs      = bus.wvalid && bus.wready;
  assign s_waddr     = s_aw_hs ? bus.awaddr : s_awaddr;
  assign s_wd        = s_w_hs ? bus.wdata : s_wdata;
  assign s_ws        = s_w_hs ? bus.wstrb : s_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0;
      s_rvalid <= 1'b0; s_wcnt <= 0;
      s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
    end else begin
      if (s_aw_hs) s_awaddr <= bus.awaddr;
      if (s_w_hs) begin s_wdata <= bus.wdata; s_wstrb <= bus.wstrb; end
      if (s_w_hs) s_wcnt <= 0;
      else if (bus.wvalid) s_wcnt <= s_wcnt + 1;
      if ((s_aw_got || s_aw_hs) && (s_w_got || s_w_hs)) begin
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
        s_bvalid <= !cfg_no_b;
        s_bresp  <= cfg_bresp;
        for (int b = 0; b < 4; b++)
          if (s_ws[b]) mem[s_waddr[4:2]][8*b +: 8] <= s_wd[8*b +: 8];
      end else begin
        if (s_aw_hs) s_aw_got <= 1'b1;
        if (s_w_hs)  s_w_got  <= 1'b1;
        if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[bus.araddr[4:2]];
        s_rresp  <= cfg_rresp;
      end else if (s_rvalid && bus.rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one command and observe 25 cycles after acceptance. lat is the
  // distance from the first cycle after acceptance to rsp_valid (-1: none).
  task automatic do_cmd(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [31:0] rd,
                        output logic [1:0] rs, output int naw, output int nw,
                        output int nrsp);
    int t0;
    lat = -1; naw = 0; nw = 0; nrsp = 0; rd = '0; rs = '0; t0 = -1;
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a;
    i_cmd_wdata = d; i_cmd_wstrb = s;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      if (o_cmd_ready) t0 = cyc + 1;
      tick();
    end
    i_cmd_valid = 1'b0;
    if (t0 < 0) return;
    for (int i = 0; i < 25; i++) begin
      if (bus.awvalid) naw++;
      if (bus.wvalid)  nw++;
      if (o_rsp_valid) begin
        nrsp++;
        if (lat < 0) begin lat = cyc - t0; rd = o_rsp_rdata; rs = o_rsp_resp; end
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", o_cmd_ready); end
    checks++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
      errors++; $display("FAIL rst_bus_ctrl got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); end
    checks++; if ({o_rsp_valid, o_rsp_resp, o_rsp_rdata} !== 35'd0) begin
      errors++; $display("FAIL rst_rsp got v=%b r=%0d d=%h want 0", o_rsp_valid, o_rsp_resp, o_rsp_rdata); end
    checks++; if ({bus.awprot, bus.arprot} !== 6'b0) begin errors++; $display("FAIL rst_prot got %b want 0", {bus.awprot, bus.arprot}); end
`ifdef AXIL_MASTER_TIMEOUT_EN
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", o_timeout); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int lat, naw, nw, nrsp; logic [31:0] rd; logic [1:0] rs;
    do_cmd(1'b1, 5'd1, 32'h2345, 4'hF, lat, rd, rs, naw, nw, nrsp);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
    checks++; if (rs !== 2'd0) begin errors++; $display("FAIL wr_resp got %0d want 0", rs); end
    checks++; if (naw !== 1 || nw !== 1) begin errors++; $display("FAIL wr_valid_cycles got aw=%0d w=%0d want 1/1", naw, nw); end
    checks++; if (nrsp !== 1) begin errors++; $display("FAIL wr_rsp_count got %0d want 1", nrsp); end
    do_cmd(1'b0, 5'd1, 32'h0, 4'h0, lat, rd, rs, naw, nw, nrsp);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h2345) begin errors++; $display("FAIL rd_data got %h want 00002345", rd); end
    checks++; if (rs !== 2'd0 || nrsp !== 1) begin errors++; $display("FAIL rd_resp got %0d n=%0d want 0 n=1", rs, nrsp); end
  endtask

  task automatic test_strobe();
    int lat, naw, nw, nrsp; logic [31:0] rd; logic [1:0] rs;
    do_cmd(1'b1, 5'd8, 32'hFFFF_FFFF, 4'hF, lat, rd, rs, naw, nw, nrsp);
    do_cmd(1'b1, 5'd8, 32'h1234_5678, 4'h3, lat, rd, rs, naw, nw, nrsp);
    do_cmd(1'b0, 5'd8, 32'h0, 4'h0, lat, rd, rs, naw, nw, nrsp);
    checks++; if (rd !== 32'hFFFF_5678) begin errors++; $display("FAIL strobe_data got %h want ffff5678", rd); end
  endtask

  task automatic test_wready_delay();
    int lat, naw, nw, nrsp; logic [31:0] rd; logic [1:0] rs;
    cfg_wdly = 3;
    do_cmd(1'b1, 5'd12, 32'hBEEF, 4'hF, lat, rd, rs, naw, nw, nrsp);
    cfg_wdly = 0;
    checks++; if (naw !== 1) begin errors++; $display("FAIL wdly_awvalid_cycles got %0d want 1", naw); end
    checks++; if (nw !== 4) begin errors++; $display("FAIL wdly_wvalid_cycles got %0d want 4", nw); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL wdly_latency got %0d want 5", lat); end
    checks++; if (nrsp !== 1) begin errors++; $display("FAIL wdly_rsp_count got %0d want 1", nrsp); end
    do_cmd(1'b0, 5'd12, 32'h0, 4'h0, lat, rd, rs, naw, nw, nrsp);
    checks++; if (rd !== 32'hBEEF) begin errors++; $display("FAIL wdly_readback got %h want 0000beef", rd); end
  endtask

  task automatic test_error_resp();
    int lat, naw, nw, nrsp; logic [31:0] rd; logic [1:0] rs;
    cfg_bresp = 2'd2;
    do_cmd(1'b1, 5'd4, 32'h7777, 4'hF, lat, rd, rs, naw, nw, nrsp);
    cfg_bresp = 2'd0;
    checks++; if (rs !== 2'd2 || nrsp !== 1) begin errors++; $display("FAIL bresp_err got %0d n=%0d want 2 n=1", rs, nrsp); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL bresp_idle got %b want 1", o_cmd_ready); end
    cfg_rresp = 2'd3;
    do_cmd(1'b0, 5'd1, 32'h0, 4'h0, lat, rd, rs, naw, nw, nrsp);
    cfg_rresp = 2'd0;
    checks++; if (lat !== 2 || rs !== 2'd3) begin errors++; $display("FAIL rresp_err got lat=%0d r=%0d want 2/3", lat, rs); end
    checks++; if (rd !== 32'h2345) begin errors++; $display("FAIL rresp_data got %h want 00002345", rd); end
  endtask

  task automatic test_back_to_back();
    int k, r1, rdy, t1, lat2;
    logic [31:0] rd1; logic [1:0] rs2;
    int lat, naw, nw, nrsp; logic [31:0] rd; logic [1:0] rs;
    k = -1; r1 = -1; rdy = -1; t1 = -1; lat2 = -1; rd1 = '0; rs2 = 2'd3;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 5'd1;
    for (int i = 0; i < 20 && k < 0; i++) begin
      if (o_cmd_ready) k = cyc + 1;
      tick();
    end
    i_cmd_write = 1'b1; i_cmd_addr = 5'd8; i_cmd_wdata = 32'hCAFE_0000; i_cmd_wstrb = 4'hF;
    for (int i = 0; i < 30 && rdy < 0; i++) begin
      if (o_rsp_valid && r1 < 0) begin r1 = cyc; rd1 = o_rsp_rdata; end
      if (o_cmd_ready) rdy = cyc;
      else tick();
    end
    tick();
    i_cmd_valid = 1'b0;
    t1 = cyc;
    for (int i = 0; i < 20 && lat2 < 0; i++) begin
      if (o_rsp_valid) begin lat2 = cyc - t1; rs2 = o_rsp_resp; end
      else tick();
    end
    checks++; if (r1 - k !== 2) begin errors++; $display("FAIL b2b_rd_latency got %0d want 2", r1 - k); end
    checks++; if (rd1 !== 32'h2345) begin errors++; $display("FAIL b2b_rd_data got %h want 00002345", rd1); end
    checks++; if (rdy - r1 !== 1) begin errors++; $display("FAIL b2b_accept_gap got %0d want 1", rdy - r1); end
    checks++; if (lat2 !== 2 || rs2 !== 2'd0) begin errors++; $display("FAIL b2b_wr got lat=%0d r=%0d want 2/0", lat2, rs2); end
    repeat (3) tick();
    do_cmd(1'b0, 5'd8, 32'h0, 4'h0, lat, rd, rs, naw, nw, nrsp);
    checks++; if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL b2b_readback got %h want cafe0000", rd); end
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    t0 = -1;
    cfg_no_b = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 5'd16;
    i_cmd_wdata = 32'h1; i_cmd_wstrb = 4'hF;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      if (o_cmd_ready) t0 = cyc + 1;
      tick();
    end
    i_cmd_valid = 1'b0;
    repeat (7) tick();
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", o_timeout); end
    tick();
    checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", o_timeout); end
    repeat (5) tick();
    checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", o_timeout); end
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_no_b = 1'b0;
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", o_timeout); end
    tick();
  endtask
`endif

  task automatic test_reset_midflight();
    int k, nrsp, lat, naw, nw, n2; logic [31:0] rd; logic [1:0] rs;
    k = -1; nrsp = 0;
    cfg_no_b = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 5'd20;
    i_cmd_wdata = 32'h55; i_cmd_wstrb = 4'hF;
    for (int i = 0; i < 20 && k < 0; i++) begin
      if (o_cmd_ready) k = cyc + 1;
      tick();
    end
    i_cmd_valid = 1'b0;
    tick();
    checks++; if (bus.bready !== 1'b1) begin errors++; $display("FAIL mid_in_wr_resp got bready=%b want 1", bus.bready); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
      errors++; $display("FAIL mid_rst_valids got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); end
    checks++; if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_user got ready=%b rsp=%b want 1/0", o_cmd_ready, o_rsp_valid); end
    rst = 1'b0;
    cfg_no_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_rsp_valid) nrsp++;
      tick();
    end
    checks++; if (nrsp !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d want 0", nrsp); end
    do_cmd(1'b0, 5'd8, 32'h0, 4'h0, lat, rd, rs, naw, nw, n2);
    checks++; if (lat !== 2 || rd !== 32'hCAFE_0000) begin
      errors++; $display("FAIL mid_recover got lat=%0d d=%h want 2/cafe0000", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_wready_delay();
    test_error_resp();
    test_back_to_back();
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
